// File: rtl/rb_write_ctrl.sv
// Write-side controller for BRAM-packed row buffers.
// Tracks frame/row/column state and rotates the active lane at each line end.
module rb_write_ctrl #(
    parameter int RBS         = 3,
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int COL_ADDR    = 10,
    parameter int RB_ADDR     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       s_sof,
    input  logic [PIXEL_WIDTH-1:0]     s_data,
    input  logic                       stall,
    output logic [RBS-1:0]             bram_we,
    output logic [COL_ADDR-1:0]        bram_waddr,
    output logic [RBS*PIXEL_WIDTH-1:0] bram_wdata,
    output logic                       bram_re,
    output logic [COL_ADDR-1:0]        bram_raddr,
    output logic [RB_ADDR-1:0]         rd_sel,
    output logic                       win_valid,
    output logic                       line_end,
    output logic                       frame_end,
    output logic                       sof_err
);

    // Wide enough that RBS-1 never aliases when IMG_HEIGHT is tiny.
    localparam int ROW_W = $clog2(IMG_HEIGHT + RBS + 1);
    localparam logic [COL_ADDR-1:0] LAST_COL = COL_ADDR'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT);
    localparam logic [ROW_W-1:0] FULL_ROW = ROW_W'(RBS - 1);
    localparam logic [RB_ADDR-1:0] LAST_PTR = RB_ADDR'(RBS - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t               state, state_n, e_state;
    logic [COL_ADDR-1:0]  col, col_n, e_col;
    logic [ROW_W-1:0]     row, row_n, e_row;
    logic [RB_ADDR-1:0]   wr_ptr, ptr_n, e_ptr, sel_n;
    logic                 acc, wr, win, le, fe, err;

    assign s_ready = rst_n & ~stall;
    assign acc     = s_valid & s_ready;
    assign sel_n   = (e_ptr == LAST_PTR) ? '0 : e_ptr + RB_ADDR'(1);

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        ptr_n   = wr_ptr;
        e_state = state;
        e_col   = col;
        e_row   = row;
        e_ptr   = wr_ptr;
        wr      = 1'b0;
        win     = 1'b0;
        le      = 1'b0;
        fe      = 1'b0;
        err     = 1'b0;
        if (acc) begin
            // A sof pixel restarts the frame from any state.
            if (s_sof) begin
                e_state = FILL;
                e_col   = '0;
                e_row   = '0;
                e_ptr   = '0;
            end
            if (e_state == IDLE) begin
                err = 1'b1;
            end else begin
                wr      = 1'b1;
                win     = (e_state == STREAM);
                state_n = e_state;
                row_n   = e_row;
                ptr_n   = e_ptr;
                if (e_col == LAST_COL) begin
                    le    = 1'b1;
                    col_n = '0;
                    row_n = e_row + ROW_W'(1);
                    ptr_n = sel_n;
                    if (row_n == LAST_ROW) begin
                        fe      = 1'b1;
                        state_n = IDLE;
                        row_n   = '0;
                        ptr_n   = '0;
                    end else if (e_state == FILL && row_n == FULL_ROW) begin
                        state_n = STREAM;
                    end
                end else begin
                    col_n = e_col + COL_ADDR'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            wr_ptr <= '0;
        end else begin
            state  <= state_n;
            col    <= col_n;
            row    <= row_n;
            wr_ptr <= ptr_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we    <= '0;
            bram_waddr <= '0;
            bram_wdata <= '0;
            bram_re    <= 1'b0;
            bram_raddr <= '0;
            rd_sel     <= '0;
            win_valid  <= 1'b0;
            line_end   <= 1'b0;
            frame_end  <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            bram_we    <= wr ? (RBS'(1) << e_ptr) : '0;
            bram_waddr <= wr ? e_col : '0;
            bram_wdata <= wr ? {RBS{s_data}} : '0;
            bram_re    <= wr;
            bram_raddr <= wr ? e_col : '0;
            rd_sel     <= wr ? sel_n : '0;
            win_valid  <= win;
            line_end   <= le;
            frame_end  <= fe;
            sof_err    <= err;
        end
    end

endmodule

// File: tb/tb_rb_write_ctrl.sv
// Directed bench for rb_write_ctrl: 3 lanes, 4x4 frames.
module tb_rb_write_ctrl;

    localparam int RBS = 3;
    localparam int PW  = 8;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int CA  = 3;
    localparam int RA  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              s_sof = 1'b0;
    logic [PW-1:0]     s_data = '0;
    logic              stall = 1'b0;
    logic [RBS-1:0]    bram_we;
    logic [CA-1:0]     bram_waddr;
    logic [RBS*PW-1:0] bram_wdata;
    logic              bram_re;
    logic [CA-1:0]     bram_raddr;
    logic [RA-1:0]     rd_sel;
    logic              win_valid;
    logic              line_end;
    logic              frame_end;
    logic              sof_err;

    int total = 0;
    int bad   = 0;

    rb_write_ctrl #(
        .RBS(RBS), .PIXEL_WIDTH(PW), .IMG_WIDTH(W),
        .IMG_HEIGHT(H), .COL_ADDR(CA), .RB_ADDR(RA)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_sof(s_sof), .s_data(s_data), .stall(stall),
        .bram_we(bram_we), .bram_waddr(bram_waddr),
        .bram_wdata(bram_wdata), .bram_re(bram_re),
        .bram_raddr(bram_raddr), .rd_sel(rd_sel),
        .win_valid(win_valid), .line_end(line_end),
        .frame_end(frame_end), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sof;
        logic [PW-1:0] data;
        logic [2:0]    we;
        logic [CA-1:0] addr;
        logic [RA-1:0] sel;
        logic          win;
        logic          le;
        logic          fe;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic sof,
                        input logic [PW-1:0] d, input logic st);
        s_valid = v;
        s_sof   = sof;
        s_data  = d;
        stall   = st;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        stall   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] lane(input int r);
        return 3'b001 << (r % 3);
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].sof  = (i == 0);
            vecs[i].data = PW'(i);
            vecs[i].we   = lane(i / 4);
            vecs[i].addr = CA'(i % 4);
            vecs[i].sel  = RA'(((i / 4) + 1) % 3);
            vecs[i].win  = (i >= 8);
            vecs[i].le   = (i % 4 == 3);
            vecs[i].fe   = (i == 15);
        end

        #3;
        chk("rst_we", int'(bram_we), 0);
        chk("rst_ready", int'(s_ready), 0);
        chk("rst_re", int'(bram_re), 0);
        chk("rst_sel", int'(rd_sel), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_idle", int'(s_ready), 1);

        // full frame
        for (int i = 0; i < 16; i++) begin
            push(1'b1, vecs[i].sof, vecs[i].data, 1'b0);
            chk($sformatf("f_we%0d", i), int'(bram_we), int'(vecs[i].we));
            chk($sformatf("f_wa%0d", i), int'(bram_waddr), int'(vecs[i].addr));
            chk($sformatf("f_ra%0d", i), int'(bram_raddr), int'(vecs[i].addr));
            chk($sformatf("f_re%0d", i), int'(bram_re), 1);
            chk($sformatf("f_wd%0d", i), int'(bram_wdata),
                int'({3{vecs[i].data}}));
            chk($sformatf("f_sel%0d", i), int'(rd_sel), int'(vecs[i].sel));
            chk($sformatf("f_win%0d", i), int'(win_valid), int'(vecs[i].win));
            chk($sformatf("f_le%0d", i), int'(line_end), int'(vecs[i].le));
            chk($sformatf("f_fe%0d", i), int'(frame_end), int'(vecs[i].fe));
        end

        // back-to-back frame
        push(1'b1, 1'b1, 8'h55, 1'b0);
        chk("b2b_we", int'(bram_we), 1);
        chk("b2b_wa", int'(bram_waddr), 0);
        chk("b2b_err", int'(sof_err), 0);
        chk("b2b_win", int'(win_valid), 0);
        push(1'b0, 1'b0, 8'h00, 1'b0);
        chk("idle_we", int'(bram_we), 0);
        chk("idle_re", int'(bram_re), 0);

        // pixels without sof are dropped
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 1'b0, PW'(8'h10 + i), 1'b0);
            chk($sformatf("ns_err%0d", i), int'(sof_err), 1);
            chk($sformatf("ns_we%0d", i), int'(bram_we), 0);
            chk($sformatf("ns_re%0d", i), int'(bram_re), 0);
        end
        push(1'b1, 1'b1, 8'hAA, 1'b0);
        chk("aa_we", int'(bram_we), 1);
        chk("aa_wa", int'(bram_waddr), 0);
        chk("aa_wd", int'(bram_wdata), 32'hAAAAAA);
        chk("aa_err", int'(sof_err), 0);

        // stall every other cycle, valid held
        begin
            int exp_col = 1;
            int writes  = 0;
            for (int i = 0; i < 8; i++) begin
                logic st;
                st = (i % 2 == 0);
                s_valid = 1'b1;
                stall   = st;
                #1;
                chk($sformatf("st_rdy%0d", i), int'(s_ready), int'(!st));
                push(1'b1, 1'b0, PW'(8'h20 + i), st);
                if (st) begin
                    chk($sformatf("st_we%0d", i), int'(bram_we), 0);
                end else begin
                    writes++;
                    chk($sformatf("st_wa%0d", i), int'(bram_waddr), exp_col);
                    chk($sformatf("st_lw%0d", i), int'(bram_we),
                        (exp_col == 0) ? 2 : 1);
                    exp_col = (exp_col + 1) % 4;
                end
            end
            chk("st_writes", writes, 4);
        end

        // sof mid-frame at row 1 col 2
        do_reset();
        for (int i = 0; i < 6; i++)
            push(1'b1, (i == 0), PW'(i), 1'b0);
        push(1'b1, 1'b1, 8'h66, 1'b0);
        chk("mid_we", int'(bram_we), 1);
        chk("mid_wa", int'(bram_waddr), 0);
        chk("mid_le", int'(line_end), 0);
        chk("mid_fe", int'(frame_end), 0);
        chk("mid_win", int'(win_valid), 0);
        for (int j = 1; j <= 12; j++) begin
            push(1'b1, 1'b0, PW'(8'h70 + j), 1'b0);
            chk($sformatf("mid_le%0d", j), int'(line_end), int'(j % 4 == 3));
            chk($sformatf("mid_win%0d", j), int'(win_valid), int'(j >= 8));
            chk($sformatf("mid_wa%0d", j), int'(bram_waddr), j % 4);
            chk($sformatf("mid_lane%0d", j), int'(bram_we), int'(lane(j / 4)));
        end

        // async reset mid-row 2
        do_reset();
        for (int i = 0; i < 10; i++)
            push(1'b1, (i == 0), PW'(i), 1'b0);
        chk("ar_pre_we", int'(bram_we), 4);
        chk("ar_pre_win", int'(win_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we", int'(bram_we), 0);
        chk("ar_re", int'(bram_re), 0);
        chk("ar_wa", int'(bram_waddr), 0);
        chk("ar_win", int'(win_valid), 0);
        chk("ar_rdy", int'(s_ready), 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(1'b1, 1'b0, 8'h99, 1'b0);
        chk("ar_err", int'(sof_err), 1);
        chk("ar_post_we", int'(bram_we), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
